// File: rtl/riscv_bus_arbiter_pkg.sv
// Shared definitions for the bus arbiter slice.
//   XLEN_DEFAULT : default address/data width when the top is not overridden.
//   arb_state_e  : arbiter sequencing states (idle, request phase, read-response phase).
package riscv_bus_arbiter_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RSP  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/riscv_mux.sv
// N-input word multiplexer over a concatenated input bus.
//   in_concat_i : input k occupies [W*(k+1)-1 -: W].
//   sel_i       : input select; values >= N_MUX_IN produce zero.
//   out_o       : selected word.
module riscv_mux #(
  parameter int N_MUX_IN = 2,
  parameter int W        = 32
) (
  input  logic [N_MUX_IN*W-1:0]       in_concat_i,
  input  logic [$clog2(N_MUX_IN)-1:0] sel_i,
  output logic [W-1:0]                out_o
);

  always_comb begin
    out_o = '0;
    for (int k = 0; k < N_MUX_IN; k++) begin
      if (int'(sel_i) == k) begin
        out_o = in_concat_i[W*k +: W];
      end
    end
  end

endmodule

// File: rtl/riscv_rr_pick.sv
// Combinational round-robin picker.
//   req_i   : request vector, one bit per requester.
//   ptr_i   : highest-priority index for this round.
//   grant_o : first set request at or above ptr_i, wrapping to 0.
//   any_o   : at least one request is set.
module riscv_rr_pick #(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0]         req_i,
  input  logic [$clog2(N_REQ)-1:0] ptr_i,
  output logic [$clog2(N_REQ)-1:0] grant_o,
  output logic                     any_o
);

  localparam int SEL_W = $clog2(N_REQ);

  logic [SEL_W-1:0] hi_idx;
  logic [SEL_W-1:0] lo_idx;
  logic             hi_found;

  // Scan downward so the last hit is the lowest index: lo_idx is the lowest
  // request overall (the wrapped choice), hi_idx the lowest at or above ptr_i.
  always_comb begin
    hi_idx   = '0;
    lo_idx   = '0;
    hi_found = 1'b0;
    any_o    = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_i[k]) begin
        any_o  = 1'b1;
        lo_idx = SEL_W'(k);
        if (k >= int'(ptr_i)) begin
          hi_found = 1'b1;
          hi_idx   = SEL_W'(k);
        end
      end
    end
    grant_o = hi_found ? hi_idx : lo_idx;
  end

endmodule

// File: rtl/riscv_bus_arbiter.sv
// Round-robin arbiter sharing one memory/bus port among N_REQ requesters,
// one outstanding transaction at a time (request phase, then read response).
//   i_clk / i_rst             : clock, synchronous active-high reset.
//   i_req_valid / i_req_we    : per-requester request valid and write enable.
//   i_req_concat_addr/wdata   : per-requester address / write data, XLEN each.
//   o_req_ready               : one-hot accept strobe to the granted requester.
//   o_rsp_valid / o_rsp_rdata : one-hot read-response valid, read data pass-through.
//   o_bus_*                   : request side of the external bus.
//   i_bus_ready/rvalid/rdata  : bus accept, read-data valid, read data.
//   o_grant_sel               : registered grant index.
module riscv_bus_arbiter
  import riscv_bus_arbiter_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int XLEN  = XLEN_DEFAULT
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [N_REQ-1:0]         i_req_valid,
  input  logic [N_REQ-1:0]         i_req_we,
  input  logic [N_REQ*XLEN-1:0]    i_req_concat_addr,
  input  logic [N_REQ*XLEN-1:0]    i_req_concat_wdata,
  output logic [N_REQ-1:0]         o_req_ready,
  output logic [N_REQ-1:0]         o_rsp_valid,
  output logic [XLEN-1:0]          o_rsp_rdata,
  output logic                     o_bus_valid,
  output logic                     o_bus_we,
  output logic [XLEN-1:0]          o_bus_addr,
  output logic [XLEN-1:0]          o_bus_wdata,
  input  logic                     i_bus_ready,
  input  logic                     i_bus_rvalid,
  input  logic [XLEN-1:0]          i_bus_rdata,
  output logic [$clog2(N_REQ)-1:0] o_grant_sel
);

  localparam int SEL_W = $clog2(N_REQ);

  arb_state_e       state_q, state_d;
  logic [SEL_W-1:0] grant_q, grant_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] pick_idx;
  logic             pick_any;
  logic [SEL_W-1:0] grant_inc;
  logic [N_REQ-1:0] grant_onehot;
  logic [XLEN-1:0]  mux_addr;
  logic [XLEN-1:0]  mux_wdata;

  riscv_rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req_i   (i_req_valid),
    .ptr_i   (ptr_q),
    .grant_o (pick_idx),
    .any_o   (pick_any)
  );

  riscv_mux #(
    .N_MUX_IN (N_REQ),
    .W        (XLEN)
  ) u_addr_mux (
    .in_concat_i (i_req_concat_addr),
    .sel_i       (o_grant_sel),
    .out_o       (mux_addr)
  );

  riscv_mux #(
    .N_MUX_IN (N_REQ),
    .W        (XLEN)
  ) u_wdata_mux (
    .in_concat_i (i_req_concat_wdata),
    .sel_i       (o_grant_sel),
    .out_o       (mux_wdata)
  );

  // Explicit wrap keeps the pointer below N_REQ when N_REQ is not a power of 2.
  assign grant_inc    = (int'(grant_q) == N_REQ - 1) ? '0 : grant_q + 1'b1;
  assign grant_onehot = N_REQ'(1) << grant_q;
  assign o_grant_sel  = grant_q;
  assign o_rsp_rdata  = i_bus_rdata;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    o_bus_valid = 1'b0;
    o_bus_we    = 1'b0;
    o_bus_addr  = '0;
    o_bus_wdata = '0;
    o_req_ready = '0;
    o_rsp_valid = '0;
    case (state_q)
      ARB_IDLE: begin
        // Requests are only sampled here; anything raised while busy waits.
        if (pick_any) begin
          grant_d = pick_idx;
          state_d = ARB_REQ;
        end
      end
      ARB_REQ: begin
        o_bus_valid = 1'b1;
        o_bus_we    = i_req_we[grant_q];
        o_bus_addr  = mux_addr;
        o_bus_wdata = mux_wdata;
        if (i_bus_ready) begin
          o_req_ready = grant_onehot;
          if (i_req_we[grant_q]) begin
            state_d = ARB_IDLE;
            ptr_d   = grant_inc;
          end else begin
            state_d = ARB_RSP;
          end
        end
      end
      ARB_RSP: begin
        if (i_bus_rvalid) begin
          o_rsp_valid = grant_onehot;
          state_d     = ARB_IDLE;
          ptr_d       = grant_inc;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_riscv_bus_arbiter.sv
module tb_riscv_bus_arbiter;

  localparam logic [31:0] WMASK = 32'hA5A5_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Two-requester instance
  logic        rst2;
  logic [1:0]  vld2, we2, rr2, rsv2;
  logic [63:0] addr2, wdata2;
  logic        rdy2, rv2, bv2, bwe2;
  logic [31:0] rdata2, rsp_rdata2, baddr2, bwdata2;
  logic        gsel2;

  // Three-requester instance
  logic        rst3;
  logic [2:0]  vld3, we3, rr3, rsv3;
  logic [95:0] addr3, wdata3;
  logic        rdy3, rv3, bv3, bwe3;
  logic [31:0] rdata3, rsp_rdata3, baddr3, bwdata3;
  logic [1:0]  gsel3;

  riscv_bus_arbiter #(.N_REQ(2), .XLEN(32)) dut2 (
    .i_clk(clk), .i_rst(rst2), .i_req_valid(vld2), .i_req_we(we2),
    .i_req_concat_addr(addr2), .i_req_concat_wdata(wdata2),
    .o_req_ready(rr2), .o_rsp_valid(rsv2), .o_rsp_rdata(rsp_rdata2),
    .o_bus_valid(bv2), .o_bus_we(bwe2), .o_bus_addr(baddr2), .o_bus_wdata(bwdata2),
    .i_bus_ready(rdy2), .i_bus_rvalid(rv2), .i_bus_rdata(rdata2), .o_grant_sel(gsel2)
  );

  riscv_bus_arbiter #(.N_REQ(3), .XLEN(32)) dut3 (
    .i_clk(clk), .i_rst(rst3), .i_req_valid(vld3), .i_req_we(we3),
    .i_req_concat_addr(addr3), .i_req_concat_wdata(wdata3),
    .o_req_ready(rr3), .o_rsp_valid(rsv3), .o_rsp_rdata(rsp_rdata3),
    .o_bus_valid(bv3), .o_bus_we(bwe3), .o_bus_addr(baddr3), .o_bus_wdata(bwdata3),
    .i_bus_ready(rdy3), .i_bus_rvalid(rv3), .i_bus_rdata(rdata3), .o_grant_sel(gsel3)
  );

  int n_checks;
  int n_pass;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Requester contract on the three-requester instance: once valid, hold until ready.
  bit         proto_on;
  logic [2:0] vld3_prev, rr3_prev;
  always @(posedge clk) begin
    if (proto_on) begin
      for (int k = 0; k < 3; k++) begin
        assert (!(vld3_prev[k] && !rr3_prev[k] && !vld3[k]))
          else $error("requester %0d dropped valid before ready", k);
      end
    end
    vld3_prev <= vld3;
    rr3_prev  <= rr3;
  end

  typedef struct {
    logic        rst;
    logic [1:0]  vld;
    logic [1:0]  we;
    logic [31:0] a0;
    logic [31:0] a1;
    logic        rdy;
    logic        rv;
    logic        bv;
    logic [31:0] addr;
    logic [1:0]  rr;
    logic [1:0]  rsv;
    logic        gsel;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic [1:0] vld, input logic [1:0] we,
                     input logic [31:0] a0, input logic [31:0] a1, input logic rdy,
                     input logic rv, input logic bv, input logic [31:0] addr,
                     input logic [1:0] rr, input logic [1:0] rsv, input logic gsel);
    vec_t v;
    v.rst = rst; v.vld = vld; v.we = we; v.a0 = a0; v.a1 = a1; v.rdy = rdy; v.rv = rv;
    v.bv = bv; v.addr = addr; v.rr = rr; v.rsv = rsv; v.gsel = gsel;
    tbl.push_back(v);
  endtask

  task automatic step3(input logic [2:0] vld, input logic rdy, input logic ebv,
                       input logic [2:0] err, input logic [1:0] egs, input string tag);
    @(negedge clk);
    vld3   = vld;
    we3    = 3'b111;
    rdy3   = rdy;
    rv3    = 1'b0;
    addr3  = {32'h3000, 32'h2000, 32'h1000};
    wdata3 = {32'h3000 ^ WMASK, 32'h2000 ^ WMASK, 32'h1000 ^ WMASK};
    #2;
    check({tag, " bus_valid"}, bv3, ebv);
    check({tag, " req_ready"}, rr3, err);
    check({tag, " grant_sel"}, gsel3, egs);
    if (ebv) check({tag, " bus_addr"}, baddr3, 32'h1000 * (egs + 1));
  endtask

  // Reference model state for the randomized phase
  int          owner;
  bit          waiting;
  int          ptr;
  int          gsel_m;
  logic [2:0]  r_vld, r_we;
  logic [31:0] r_addr[3];
  logic [31:0] r_wd[3];

  initial begin
    n_checks = 0;
    n_pass   = 0;
    proto_on = 1'b0;
    rst2 = 1'b1; vld2 = '0; we2 = '0; addr2 = '0; wdata2 = '0; rdy2 = 1'b0; rv2 = 1'b0; rdata2 = '0;
    rst3 = 1'b1; vld3 = '0; we3 = '0; addr3 = '0; wdata3 = '0; rdy3 = 1'b0; rv3 = 1'b0; rdata3 = '0;
    repeat (2) @(negedge clk);
    rst2 = 1'b0;
    rst3 = 1'b0;

    // Idle after reset
    for (int i = 0; i < 5; i++) add(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    // Requester 1 read of 0x100, zero-wait accept, rvalid two cycles after accept
    add(0, 2'b10, 2'b00, 0, 32'h100, 1, 0, 0, 0,        2'b00, 2'b00, 0);
    add(0, 2'b10, 2'b00, 0, 32'h100, 1, 0, 1, 32'h100,  2'b10, 2'b00, 1);
    add(0, 2'b00, 2'b00, 0, 0,       1, 0, 0, 0,        2'b00, 2'b00, 1);
    add(0, 2'b00, 2'b00, 0, 0,       1, 1, 0, 0,        2'b00, 2'b10, 1);
    add(0, 2'b00, 2'b00, 0, 0,       0, 1, 0, 0,        2'b00, 2'b00, 1);
    // Both requesters writing continuously: grants alternate
    for (int i = 0; i < 2; i++) begin
      add(0, 2'b11, 2'b11, 32'h10, 32'h20, 1, 0, 0, 0,       2'b00, 2'b00, 1);
      add(0, 2'b11, 2'b11, 32'h10, 32'h20, 1, 0, 1, 32'h10,  2'b01, 2'b00, 0);
      add(0, 2'b11, 2'b11, 32'h10, 32'h20, 1, 0, 0, 0,       2'b00, 2'b00, 0);
      add(0, 2'b11, 2'b11, 32'h10, 32'h20, 1, 0, 1, 32'h20,  2'b10, 2'b00, 1);
    end
    add(0, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 1);
    // Requester 0 write with bus stalled four cycles
    add(0, 2'b01, 2'b01, 32'h40, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1);
    for (int i = 0; i < 4; i++) add(0, 2'b01, 2'b01, 32'h40, 0, 0, 0, 1, 32'h40, 2'b00, 2'b00, 0);
    add(0, 2'b01, 2'b01, 32'h40, 0, 1, 0, 1, 32'h40, 2'b01, 2'b00, 0);
    add(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    // Reset during RSP abandons the read and clears the pointer (it was 1)
    add(0, 2'b01, 2'b00, 32'h300, 0, 0, 0, 0, 0,        2'b00, 2'b00, 0);
    add(0, 2'b01, 2'b00, 32'h300, 0, 1, 0, 1, 32'h300,  2'b01, 2'b00, 0);
    add(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0,              2'b00, 2'b00, 0);
    add(0, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0,              2'b00, 2'b00, 0);
    add(0, 2'b11, 2'b11, 32'h10, 32'h20, 1, 0, 0, 0,       2'b00, 2'b00, 0);
    add(0, 2'b11, 2'b11, 32'h10, 32'h20, 1, 0, 1, 32'h10,  2'b01, 2'b00, 0);
    add(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0,              2'b00, 2'b00, 0);

    foreach (tbl[i]) begin
      @(negedge clk);
      rst2   = tbl[i].rst;
      vld2   = tbl[i].vld;
      we2    = tbl[i].we;
      addr2  = {tbl[i].a1, tbl[i].a0};
      wdata2 = {tbl[i].a1 ^ WMASK, tbl[i].a0 ^ WMASK};
      rdy2   = tbl[i].rdy;
      rv2    = tbl[i].rv;
      rdata2 = 32'hDEADBEEF;
      #2;
      check($sformatf("row%0d bus_valid", i), bv2, tbl[i].bv);
      check($sformatf("row%0d req_ready", i), rr2, tbl[i].rr);
      check($sformatf("row%0d rsp_valid", i), rsv2, tbl[i].rsv);
      check($sformatf("row%0d grant_sel", i), gsel2, tbl[i].gsel);
      if (tbl[i].bv) begin
        check($sformatf("row%0d bus_addr", i), baddr2, tbl[i].addr);
        check($sformatf("row%0d bus_wdata", i), bwdata2, tbl[i].addr ^ WMASK);
        check($sformatf("row%0d bus_we", i), bwe2, tbl[i].we[tbl[i].gsel]);
      end
      if (tbl[i].rsv != 2'b00) check($sformatf("row%0d rsp_rdata", i), rsp_rdata2, 32'hDEADBEEF);
    end

    // Three requesters: pointer wraps 2 -> 0
    step3(3'b100, 1'b0, 1'b0, 3'b000, 2'd0, "wrap c1");
    step3(3'b100, 1'b1, 1'b1, 3'b100, 2'd2, "wrap c2");
    step3(3'b101, 1'b0, 1'b0, 3'b000, 2'd2, "wrap c3");
    step3(3'b101, 1'b1, 1'b1, 3'b001, 2'd0, "wrap c4");
    step3(3'b101, 1'b0, 1'b0, 3'b000, 2'd0, "wrap c5");
    step3(3'b101, 1'b1, 1'b1, 3'b100, 2'd2, "wrap c6");

    // Randomized traffic against the transaction-level model
    @(negedge clk);
    rst3 = 1'b1; vld3 = '0; rdy3 = 1'b0; rv3 = 1'b0;
    @(negedge clk);
    rst3 = 1'b0;
    proto_on = 1'b1;
    owner = -1; waiting = 1'b0; ptr = 0; gsel_m = 0;
    r_vld = '0; r_we = '0;
    for (int k = 0; k < 3; k++) begin r_addr[k] = '0; r_wd[k] = '0; end

    for (int cyc = 0; cyc < 400; cyc++) begin
      logic        e_bv, e_we;
      logic [31:0] e_addr, e_wd;
      logic [2:0]  e_rr, e_rsv;
      if (cyc != 0) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (!r_vld[k] && $urandom_range(2) == 0) begin
          r_vld[k]  = 1'b1;
          r_we[k]   = 1'($urandom_range(1));
          r_addr[k] = $urandom;
          r_wd[k]   = $urandom;
        end
        addr3[32*k +: 32]  = r_addr[k];
        wdata3[32*k +: 32] = r_wd[k];
      end
      vld3   = r_vld;
      we3    = r_we;
      rdy3   = 1'($urandom_range(1));
      rv3    = 1'($urandom_range(1));
      rdata3 = $urandom;
      #2;
      e_bv = 1'b0; e_we = 1'b0; e_addr = '0; e_wd = '0; e_rr = '0; e_rsv = '0;
      if (owner >= 0 && !waiting) begin
        e_bv   = 1'b1;
        e_we   = r_we[owner];
        e_addr = r_addr[owner];
        e_wd   = r_wd[owner];
        if (rdy3) e_rr[owner] = 1'b1;
      end
      if (owner >= 0 && waiting && rv3) e_rsv[owner] = 1'b1;
      check($sformatf("rnd%0d bus_valid", cyc), bv3, e_bv);
      check($sformatf("rnd%0d req_ready", cyc), rr3, e_rr);
      check($sformatf("rnd%0d rsp_valid", cyc), rsv3, e_rsv);
      check($sformatf("rnd%0d grant_sel", cyc), gsel3, gsel_m);
      check($sformatf("rnd%0d rsp_rdata", cyc), rsp_rdata3, rdata3);
      if (e_bv) begin
        check($sformatf("rnd%0d bus_we", cyc), bwe3, e_we);
        check($sformatf("rnd%0d bus_addr", cyc), baddr3, e_addr);
        check($sformatf("rnd%0d bus_wdata", cyc), bwdata3, e_wd);
      end
      // Advance the model across the coming clock edge
      if (owner < 0) begin
        for (int d = 0; d < 3; d++) begin
          if (owner < 0 && r_vld[(ptr + d) % 3]) owner = (ptr + d) % 3;
        end
        if (owner >= 0) gsel_m = owner;
      end else if (!waiting) begin
        if (rdy3) begin
          r_vld[owner] = 1'b0;
          if (r_we[owner]) begin
            ptr   = (owner + 1) % 3;
            owner = -1;
          end else begin
            waiting = 1'b1;
          end
        end
      end else if (rv3) begin
        ptr     = (owner + 1) % 3;
        owner   = -1;
        waiting = 1'b0;
      end
    end

    proto_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
